ex_muldiv_unit: RTL and testbench

- EX-stage multiply/divide unit for the 5-stage pipeline; owns the architectural HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX decode and runs mul/div as multi-cycle background operations.
- Exports busy/stall_req to stall detection so MFHI/MFLO and later mul/div ops hold in ID/EX until completion.
- HI/LO values feed the EX result mux for MFHI/MFLO, which then flows into EX_MEM as EXout.

---
 rtl/ex_muldiv_unit_pkg.sv | 33 +++
 rtl/ex_muldiv_unit_div_core.sv | 57 +++++
 rtl/ex_muldiv_unit.sv | 150 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared types and constants for the EX-stage multiply/divide unit.
`default_nettype none

package ex_muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MUL    = 2'd1,
    ST_DIV    = 2'd2,
    ST_DIVFIX = 2'd3
  } md_state_t;

  localparam int DIV_ITERS   = 32;
  localparam int DIV_LATENCY = DIV_ITERS + 1;

  function automatic logic is_arith(md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_muldiv_unit_div_core.sv
// Iterative restoring unsigned divider: loads on start, one quotient bit per cycle.
`default_nettype none

module md_div_core
  import ex_muldiv_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        valid
);

  logic [31:0] rem_q, quo_q, dvs_q;
  logic [5:0]  cnt_q;
  logic        act_q;
  logic [32:0] rem_sh_w, diff_w;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  assign rem_sh_w = {rem_q, quo_q[31]};
  assign diff_w   = rem_sh_w - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      act_q <= 1'b0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= 6'(DIV_ITERS);
      act_q <= 1'b1;
    end else if (cnt_q != 6'd0) begin
      if (!diff_w[32]) begin
        rem_q <= diff_w[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= rem_sh_w[31:0];
        quo_q <= {quo_q[30:0], 1'b0};
      end
      cnt_q <= cnt_q - 6'd1;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign valid     = act_q & (cnt_q == 6'd0);

endmodule

`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit owning HI/LO; mul/div run as multi-cycle background ops.
`default_nettype none

module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        flush,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = 5;

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, b_q, hi_q, lo_q, hi_d, lo_d;
  logic             sgn_q, done_q;

  md_op_t      op_w;
  logic        accept_w, mul_acc_w, div_acc_w, signed_op_w;
  logic        mul_wr_w, div_wr_w;
  logic [63:0] ma_w, mb_w, prod_w;
  logic [31:0] dvd_w, dvs_w, quo_w, rem_w;
  logic        div_valid_w, q_neg_w, r_neg_w;

  assign op_w        = md_op_t'(op);
  assign accept_w    = start & ~flush & (state_q == ST_IDLE);
  assign mul_acc_w   = accept_w & ((op_w == MD_MULT) | (op_w == MD_MULTU));
  assign div_acc_w   = accept_w & ((op_w == MD_DIV) | (op_w == MD_DIVU));
  assign signed_op_w = (op_w == MD_MULT) | (op_w == MD_DIV);

  // Divider works on magnitudes; signs are reapplied in DIVFIX from the latched operands.
  assign dvd_w = (signed_op_w & a[31]) ? -a : a;
  assign dvs_w = (signed_op_w & b[31]) ? -b : b;

  md_div_core u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_acc_w),
    .dividend  (dvd_w),
    .divisor   (dvs_w),
    .quotient  (quo_w),
    .remainder (rem_w),
    .valid     (div_valid_w)
  );

  assign ma_w    = {{32{sgn_q & a_q[31]}}, a_q};
  assign mb_w    = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod_w  = ma_w * mb_w;
  assign q_neg_w = sgn_q & (a_q[31] ^ b_q[31]);
  assign r_neg_w = sgn_q & a_q[31];

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mul_acc_w) begin
          state_d = ST_MUL;
          cnt_d   = CNT_W'(MUL_LATENCY - 1);
        end else if (div_acc_w) begin
          state_d = ST_DIV;
          cnt_d   = CNT_W'(DIV_ITERS - 1);
        end
      end
      ST_MUL: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_DIV: begin
        if (cnt_q == '0) state_d = ST_DIVFIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_DIVFIX: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    stall_req = busy | (start & is_arith(op_w));
    mul_wr_w  = (state_q == ST_MUL) && (cnt_q == '0);
    div_wr_w  = (state_q == ST_DIVFIX) && div_valid_w;
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (accept_w && (op_w == MD_MTHI)) hi_d = a;
    if (accept_w && (op_w == MD_MTLO)) lo_d = a;
    if (mul_wr_w) begin
      hi_d = prod_w[63:32];
      lo_d = prod_w[31:0];
    end
    if (div_wr_w) begin
      if (b_q == '0) begin
        lo_d = 32'hFFFF_FFFF;
        hi_d = a_q;
      end else begin
        lo_d = q_neg_w ? -quo_w : quo_w;
        hi_d = r_neg_w ? -rem_w : rem_w;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= mul_wr_w | div_wr_w;
      if (mul_acc_w | div_acc_w) begin
        a_q   <= a;
        b_q   <= b;
        sgn_q <= signed_op_w;
      end
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit against a plain-arithmetic HI/LO model.
`default_nettype none

module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  localparam int ML = 5;
  localparam int DL = 33;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, stall_req, done;
  logic [31:0] hi, lo;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_hi, exp_lo;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.MUL_LATENCY(ML)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .flush     (flush),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural effect of one instruction on HI/LO.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    longint      sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      MD_MULT:  begin p = 64'(sx * sy); exp_hi = p[63:32]; exp_lo = p[31:0]; end
      MD_MULTU: begin p = {32'd0, x} * {32'd0, y}; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      MD_DIV: begin
        if (y == 0) begin exp_lo = 32'hFFFF_FFFF; exp_hi = x; end
        else begin exp_lo = 32'(sx / sy); exp_hi = 32'(sx % sy); end
      end
      MD_DIVU: begin
        if (y == 0) begin exp_lo = 32'hFFFF_FFFF; exp_hi = x; end
        else begin exp_lo = x / y; exp_hi = x % y; end
      end
      MD_MTHI: exp_hi = x;
      MD_MTLO: exp_lo = x;
      default: ;
    endcase
  endtask

  // Called and returns at a negedge; holds start for exactly one rising edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    #1;
    check_val("stall_accept", {63'd0, stall_req}, {63'd0, is_arith(md_op_t'(o))});
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit intrude);
    int lat, nb;
    bit seen;
    lat = (o == MD_MULT || o == MD_MULTU) ? ML : DL;
    model(o, x, y);
    issue(o, x, y);
    nb = 0;
    seen = 0;
    for (int n = 0; n < 80; n++) begin
      if (intrude && n == 0) begin start = 1'b1; op = MD_MULT; a = 32'd5; b = 32'd7; end
      else if (intrude && n == 1) start = 1'b0;
      if (done) begin seen = 1; break; end
      if (busy) nb++;
      @(negedge clk);
    end
    check_val("done_seen", {63'd0, seen}, 64'd1);
    check_val("busy_cycles", 64'(nb), 64'(lat));
    check_val("hi", {32'd0, hi}, {32'd0, exp_hi});
    check_val("lo", {32'd0, lo}, {32'd0, exp_lo});
    @(negedge clk);
    check_val("done_pulse", {63'd0, done}, 64'd0);
    check_val("busy_after", {63'd0, busy}, 64'd0);
  endtask

  task automatic run_mt(input logic [2:0] o, input logic [31:0] x);
    model(o, x, 32'd0);
    issue(o, x, 32'd0);
    check_val("mt_hi", {32'd0, hi}, {32'd0, exp_hi});
    check_val("mt_lo", {32'd0, lo}, {32'd0, exp_lo});
    check_val("mt_busy", {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    int nd;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    exp_hi = '0; exp_lo = '0;
    repeat (2) @(negedge clk);
    check_val("rst_hi", {32'd0, hi}, 64'd0);
    check_val("rst_lo", {32'd0, lo}, 64'd0);
    check_val("rst_flags", {61'd0, busy, done, stall_req}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_md(MD_MULT,  32'hFFFF_FFFE, 32'd3, 0);
    run_md(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_md(MD_DIV,   32'hFFFF_FFF9, 32'd2, 0);
    run_md(MD_DIVU,  32'd7, 32'd0, 0);
    run_md(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_md(MD_DIV,   32'h8000_0005, 32'd0, 0);

    run_mt(MD_MTHI, 32'h1234);
    run_mt(MD_MTLO, 32'h5678);

    // Reserved op code behaves as no-op.
    run_mt(3'd7, 32'hDEAD_BEEF);

    // Flushed start must not be accepted.
    start = 1'b1; flush = 1'b1; op = MD_DIV; a = 32'd100; b = 32'd3;
    #1;
    check_val("stall_flush", {63'd0, stall_req}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check_val("flush_busy", {63'd0, busy}, 64'd0);
    nd = 0;
    repeat (40) begin
      if (done) nd++;
      @(negedge clk);
    end
    check_val("flush_done", 64'(nd), 64'd0);
    check_val("flush_hilo", {hi, lo}, {exp_hi, exp_lo});

    // Start while busy is ignored; the DIV result stands.
    run_md(MD_DIV, 32'd1000, 32'hFFFF_FFF9, 1);

    // Reset in the middle of a divide.
    model(MD_DIVU, 32'd12345, 32'd10);
    issue(MD_DIVU, 32'd12345, 32'd10);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_hi = '0; exp_lo = '0;
    check_val("midrst_busy", {62'd0, busy, done}, 64'd0);
    check_val("midrst_hilo", {hi, lo}, 64'd0);
    nd = 0;
    repeat (40) begin
      if (done || busy) nd++;
      @(negedge clk);
    end
    check_val("midrst_quiet", 64'(nd), 64'd0);
    run_md(MD_MULT, 32'd3, 32'd4, 0);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(1, 6));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if (ro == MD_MTHI || ro == MD_MTLO) run_mt(ro, ra);
      else                                run_md(ro, ra, rb, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
